// File: rtl/conv_kxk_mac_pipe_if.sv
// Handshake/bus bundle for conv_kxk_mac_pipe.
// master: window generator + output writer side (drives beats, out_ready).
// slave:  the conv MAC pipeline itself.
interface conv_kxk_mac_pipe_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int KSIZE       = 3,
  parameter int BIAS_WIDTH  = 32,
  parameter int SCALE_WIDTH = 32,
  parameter int OUT_WIDTH   = 8
);
  localparam int KK = KSIZE * KSIZE;

  logic                          in_valid;
  logic                          in_ready;
  logic                          in_first;
  logic                          in_last;
  logic [KK*DATA_WIDTH-1:0]      in_data;
  logic [KK*DATA_WIDTH-1:0]      in_weight;
  logic signed [BIAS_WIDTH-1:0]  bias;
  logic signed [SCALE_WIDTH-1:0] scale;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [OUT_WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_first, in_last, in_data, in_weight, bias, scale, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_first, in_last, in_data, in_weight, bias, scale, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv_kxk_mac_pipe.sv
// Pipelined KSIZE x KSIZE conv MAC with channel accumulation and requantisation.
// Stages: S1 products, S2 adder tree, S3 channel accumulator (+bias on last),
// S4 scale multiply, S5 rounding shift, output register (saturate + ReLU).
// A single global advance (adv) stalls the whole pipe on output backpressure.
// Optional feature macro: CONV_KXK_RELU_EN (clamp negative results to 0).
module conv_kxk_mac_pipe #(
  parameter int DATA_WIDTH  = 8,
  parameter int KSIZE       = 3,
  parameter int ACC_WIDTH   = 32,
  parameter int BIAS_WIDTH  = 32,
  parameter int SCALE_WIDTH = 32,
  parameter int SHIFT       = 16,
  parameter int OUT_WIDTH   = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  conv_kxk_mac_pipe_if.slave  bus
);
  localparam int KK     = KSIZE * KSIZE;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int P_W    = ACC_WIDTH + SCALE_WIDTH;
  localparam int R_W    = P_W + 1 - SHIFT;

  // One extra bit on the rounding add so p + half can never wrap.
  localparam logic signed [P_W:0]           ROUND   = (P_W + 1)'(1) << (SHIFT - 1);
  localparam logic signed [OUT_WIDTH-1:0]   OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0]   OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  logic adv;

  logic signed [PROD_W-1:0]      prod_w     [KK];
  logic signed [PROD_W-1:0]      s1_prod_q  [KK];
  logic signed [PROD_W-1:0]      s1_prod_d  [KK];
  logic                          s1_valid_q, s1_valid_d;
  logic                          s1_first_q, s1_first_d;
  logic                          s1_last_q,  s1_last_d;
  logic signed [BIAS_WIDTH-1:0]  s1_bias_q,  s1_bias_d;
  logic signed [SCALE_WIDTH-1:0] s1_scale_q, s1_scale_d;

  logic signed [ACC_WIDTH-1:0]   tree_sum;
  logic                          s2_valid_q, s2_valid_d;
  logic                          s2_first_q, s2_first_d;
  logic                          s2_last_q,  s2_last_d;
  logic signed [ACC_WIDTH-1:0]   s2_sum_q,   s2_sum_d;
  logic signed [BIAS_WIDTH-1:0]  s2_bias_q,  s2_bias_d;
  logic signed [SCALE_WIDTH-1:0] s2_scale_q, s2_scale_d;

  logic signed [ACC_WIDTH-1:0]   acc_next;
  logic signed [ACC_WIDTH-1:0]   acc_q,      acc_d;
  logic                          s3_valid_q, s3_valid_d;
  logic signed [ACC_WIDTH-1:0]   s3_val_q,   s3_val_d;
  logic signed [SCALE_WIDTH-1:0] s3_scale_q, s3_scale_d;

  logic                          s4_valid_q, s4_valid_d;
  logic signed [P_W-1:0]         s4_p_q,     s4_p_d;

  logic signed [P_W:0]           rnd_full;
  logic                          s5_valid_q, s5_valid_d;
  logic signed [R_W-1:0]         s5_r_q,     s5_r_d;

  logic signed [OUT_WIDTH-1:0]   sat_w;
  logic signed [OUT_WIDTH-1:0]   relu_w;
  logic                          out_valid_q, out_valid_d;
  logic signed [OUT_WIDTH-1:0]   out_data_q,  out_data_d;

  // Whole pipe moves only when the output register can take a new value.
  assign adv           = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Tap-wise signed products of window and kernel.
  always_comb begin
    for (int i = 0; i < KK; i++) begin
      prod_w[i] = PROD_W'($signed(bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]))
                * PROD_W'($signed(bus.in_weight[i*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // S1: capture products and per-beat side info.
  always_comb begin
    // NOTE: every output gets a hold default first so no path can infer a latch.
    s1_prod_d  = s1_prod_q;
    s1_valid_d = s1_valid_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_bias_d  = s1_bias_q;
    s1_scale_d = s1_scale_q;
    if (adv) begin
      s1_prod_d  = prod_w;
      s1_valid_d = bus.in_valid;
      s1_first_d = bus.in_first;
      s1_last_d  = bus.in_last;
      s1_bias_d  = bus.bias;
      s1_scale_d = bus.scale;
    end
  end

  // S2: adder tree over the products, sign-extended to the accumulator width.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < KK; i++) begin
      tree_sum = tree_sum + ACC_WIDTH'(s1_prod_q[i]);
    end
    s2_valid_d = s2_valid_q;
    s2_first_d = s2_first_q;
    s2_last_d  = s2_last_q;
    s2_sum_d   = s2_sum_q;
    s2_bias_d  = s2_bias_q;
    s2_scale_d = s2_scale_q;
    if (adv) begin
      s2_valid_d = s1_valid_q;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      s2_sum_d   = tree_sum;
      s2_bias_d  = s1_bias_q;
      s2_scale_d = s1_scale_q;
    end
  end

  // S3: channel accumulator; on the last channel emit acc+bias and clear acc.
  always_comb begin
    acc_next   = s2_first_q ? s2_sum_q : acc_q + s2_sum_q;
    acc_d      = acc_q;
    s3_valid_d = s3_valid_q;
    s3_val_d   = s3_val_q;
    s3_scale_d = s3_scale_q;
    if (adv) begin
      s3_valid_d = 1'b0;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          s3_valid_d = 1'b1;
          s3_val_d   = acc_next + ACC_WIDTH'(s2_bias_q);
          s3_scale_d = s2_scale_q;
          acc_d      = '0;
        end else begin
          acc_d = acc_next;
        end
      end
    end
  end

  // S4: full-width fixed-point scale multiply.
  always_comb begin
    s4_valid_d = s4_valid_q;
    s4_p_d     = s4_p_q;
    if (adv) begin
      s4_valid_d = s3_valid_q;
      s4_p_d     = P_W'(s3_val_q) * P_W'(s3_scale_q);
    end
  end

  // S5: round half toward +inf, then arithmetic shift.
  always_comb begin
    rnd_full   = (P_W + 1)'(s4_p_q) + ROUND;
    s5_valid_d = s5_valid_q;
    s5_r_d     = s5_r_q;
    if (adv) begin
      s5_valid_d = s4_valid_q;
      s5_r_d     = R_W'(rnd_full >>> SHIFT);
    end
  end

  // Output: saturate to OUT_WIDTH, optional ReLU, register result.
  always_comb begin
    if (s5_r_q > R_W'(OUT_MAX)) begin
      sat_w = OUT_MAX;
    end else if (s5_r_q < R_W'(OUT_MIN)) begin
      sat_w = OUT_MIN;
    end else begin
      sat_w = s5_r_q[OUT_WIDTH-1:0];
    end
`ifdef CONV_KXK_RELU_EN
    relu_w = sat_w[OUT_WIDTH-1] ? '0 : sat_w;
`else
    relu_w = sat_w;
`endif
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (adv) begin
      out_valid_d = s5_valid_q;
      if (s5_valid_q) begin
        out_data_d = relu_w;
      end
    end
  end

  // State registers for every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset along with the valids so a reset
      // mid-pixel leaves no stale partial sums and simulation carries no X.
      for (int i = 0; i < KK; i++) begin
        s1_prod_q[i] <= '0;
      end
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_bias_q   <= '0;
      s1_scale_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_sum_q    <= '0;
      s2_bias_q   <= '0;
      s2_scale_q  <= '0;
      acc_q       <= '0;
      s3_valid_q  <= 1'b0;
      s3_val_q    <= '0;
      s3_scale_q  <= '0;
      s4_valid_q  <= 1'b0;
      s4_p_q      <= '0;
      s5_valid_q  <= 1'b0;
      s5_r_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_prod_q   <= s1_prod_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_bias_q   <= s1_bias_d;
      s1_scale_q  <= s1_scale_d;
      s2_valid_q  <= s2_valid_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_sum_q    <= s2_sum_d;
      s2_bias_q   <= s2_bias_d;
      s2_scale_q  <= s2_scale_d;
      acc_q       <= acc_d;
      s3_valid_q  <= s3_valid_d;
      s3_val_q    <= s3_val_d;
      s3_scale_q  <= s3_scale_d;
      s4_valid_q  <= s4_valid_d;
      s4_p_q      <= s4_p_d;
      s5_valid_q  <= s5_valid_d;
      s5_r_q      <= s5_r_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: tb/tb_conv_kxk_mac_pipe.sv
// Directed, table-driven bench for conv_kxk_mac_pipe (default parameters).
// Expected values follow CONV_KXK_RELU_EN if the bench is built with it.
module tb_conv_kxk_mac_pipe;
  localparam int KK = 9;
  localparam int DW = 8;
`ifdef CONV_KXK_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  conv_kxk_mac_pipe_if bus ();

  conv_kxk_mac_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    int nd;     // number of data taps carrying dv (rest 0)
    int dv;
    int wv;     // value on all weight taps
    int bias;
    int scale;
    int exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int relu(input int v);
    return (RELU && v < 0) ? 0 : v;
  endfunction

  function automatic logic [KK*DW-1:0] taps(input int n, input int v);
    logic [KK*DW-1:0] r;
    r = '0;
    for (int i = 0; i < KK; i++) begin
      if (i < n) r[i*DW +: DW] = v[7:0];
    end
    return r;
  endfunction

  // Starts and ends 1 ns after a rising edge; returns right after the accept edge.
  task automatic drive_beat(input logic [KK*DW-1:0] d, input logic [KK*DW-1:0] w,
                            input bit f, input bit l, input int b, input int s);
    int n;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_weight = w;
    bus.in_first  = f;
    bus.in_last   = l;
    bus.bias      = b;
    bus.scale     = s;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) check("beat_accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Waits for out_valid, checks latency and value, then checks it is consumed once.
  task automatic expect_output(input string name, input int exp, input int exp_lat);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 15) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_data"}, $signed(bus.out_data), exp);
    @(posedge clk); #1;
    check({name, "_no_dup"}, bus.out_valid, 0);
  endtask

  task automatic backpressure_test();
    int  sent;
    int  stall_left;
    bit  stalled_once;
    bit  in_fire;
    bit  out_fire;
    int  od;
    int  got[$];
    sent = 0;
    stall_left = 0;
    stalled_once = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (sent < 4) begin
        bus.in_valid  = 1'b1;
        bus.in_first  = 1'b1;
        bus.in_last   = 1'b1;
        bus.in_data   = taps(1, 18 + sent);
        bus.in_weight = taps(1, 1);
        bus.bias      = 0;
        bus.scale     = 65536;
      end else begin
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
      end
      if (!stalled_once && bus.out_valid) begin
        stalled_once = 1'b1;
        stall_left   = 4;
      end
      bus.out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        check("bp_in_ready_low", bus.in_ready, 0);
        check("bp_valid_held", bus.out_valid, 1);
        check("bp_data_held", $signed(bus.out_data), 18);
        stall_left--;
      end
      in_fire  = bus.in_valid && bus.in_ready;
      out_fire = bus.out_valid && bus.out_ready;
      od       = $signed(bus.out_data);
      @(posedge clk); #1;
      if (in_fire) sent++;
      if (out_fire) got.push_back(od);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_stall_happened", stalled_once, 1);
    check("bp_count", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) begin
      check($sformatf("bp_seq%0d", i), got[i], 18 + i);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus.in_weight = '0;
    bus.bias      = '0;
    bus.scale     = '0;
    bus.out_ready = 1'b1;

    vecs[0] = '{9,    1,   2,   0,  65536, 18};
    vecs[1] = '{9,  127, 127,   0,  65536, 127};
    vecs[2] = '{9, -128, 127,   0,  65536, relu(-128)};
    vecs[3] = '{3,    1,   1,   0,  32768, 2};
    vecs[4] = '{3,   -1,   1,   0,  32768, relu(-1)};
    vecs[5] = '{1,    1,   1,   0,  32768, 1};
    vecs[6] = '{1,   -1,   1,   0,  32768, 0};
    vecs[7] = '{9,    1,   1, -20,  65536, relu(-11)};
    vecs[8] = '{1,    5,   3,   0, 131072, 30};
    vecs[9] = '{9,    1,   1,   0, -65536, relu(-9)};

    // Reset state.
    #1;
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", $signed(bus.out_data), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-channel vectors.
    for (int i = 0; i < 10; i++) begin
      drive_beat(taps(vecs[i].nd, vecs[i].dv), taps(KK, vecs[i].wv), 1'b1, 1'b1,
                 vecs[i].bias, vecs[i].scale);
      expect_output($sformatf("vec%0d", i), vecs[i].exp, 5);
    end

    // Three channels back to back.
    drive_beat(taps(KK, 1), taps(KK, 2), 1'b1, 1'b0, 0, 65536);
    check("multi_no_out_beat1", bus.out_valid, 0);
    drive_beat(taps(KK, 1), taps(KK, 2), 1'b0, 1'b0, 0, 65536);
    check("multi_no_out_beat2", bus.out_valid, 0);
    drive_beat(taps(KK, 1), taps(KK, 2), 1'b0, 1'b1, 6, 65536);
    expect_output("multi3", 60, 5);

    // Three channels with idle bubbles between beats.
    drive_beat(taps(KK, 1), taps(KK, 2), 1'b1, 1'b0, 0, 65536);
    idle(3);
    drive_beat(taps(KK, 1), taps(KK, 2), 1'b0, 1'b0, 0, 65536);
    idle(2);
    check("bubble_no_out", bus.out_valid, 0);
    drive_beat(taps(KK, 1), taps(KK, 2), 1'b0, 1'b1, 6, 65536);
    expect_output("bubble3", 60, 5);

    // Next pixel without in_first: accumulator was cleared by the previous last.
    drive_beat(taps(1, 7), taps(1, 1), 1'b0, 1'b1, 0, 65536);
    expect_output("no_first_after_last", 7, 5);

    // Output backpressure mid-stream.
    backpressure_test();
    idle(2);

    // Reset mid-pixel, then a clean single-channel pixel.
    drive_beat(taps(KK, 1), taps(KK, 2), 1'b1, 1'b0, 0, 65536);
    drive_beat(taps(KK, 1), taps(KK, 2), 1'b0, 1'b0, 0, 65536);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(6);
    check("rst_mid_no_stale_out", bus.out_valid, 0);
    drive_beat(taps(1, 5), taps(1, 1), 1'b1, 1'b1, 0, 65536);
    expect_output("rst_mid_pixel", 5, 5);

    // Reset mid-pixel, then a last-only beat: acc must have been cleared by reset.
    drive_beat(taps(KK, 1), taps(KK, 2), 1'b1, 1'b0, 0, 65536);
    idle(3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_beat(taps(1, 4), taps(1, 1), 1'b0, 1'b1, 0, 65536);
    expect_output("rst_acc_cleared", 4, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_kxk_mac_pipe.md
Name: conv_kxk_mac_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle 3x3 conv calculator.
- Computes one KSIZE x KSIZE dot product per beat and accumulates it over input channels, framed by first/last flags.
- On the last channel it adds bias, multiplies by a fixed-point scale, then applies rounding shift, saturation and optional ReLU.
- Sits between the line-buffer/window generator and the output feature-map writer, with valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 8, signed width of each pixel and each weight.
- KSIZE, 3, kernel side; KK = KSIZE*KSIZE taps (1 gives a 1x1 conv).
- ACC_WIDTH, 32, signed channel-accumulator width.
- BIAS_WIDTH, 32, signed bias width.
- SCALE_WIDTH, 32, signed requant scale width.
- SHIFT, 16, right-shift applied after scaling; must be >= 1.
- OUT_WIDTH, 8, signed result width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_first  in  1  first input channel of an output pixel.
- in_last  in  1  last input channel of an output pixel.
- in_data  in  KK*DATA_WIDTH  window, tap i at bits [i*DATA_WIDTH +: DATA_WIDTH], row-major.
- in_weight  in  KK*DATA_WIDTH  kernel, same packing as in_data.
- bias  in  BIAS_WIDTH  sampled with the beat carrying in_last.
- scale  in  SCALE_WIDTH  sampled with the beat carrying in_last.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_WIDTH  requantised result.

Behaviour:
- Reset: all pipeline valids, out_valid, out_data and the accumulator go to 0. in_ready is combinational, so it reads 1 while in reset.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. When adv = 0, every stage holds, including the accumulator and its flags.
- S1: registers the KK products, each signed 2*DATA_WIDTH, together with first/last/bias/scale.
- S2: registers the adder-tree sum, sign-extended to ACC_WIDTH.
- S3 (accumulator):
  - On a valid beat, acc = first ? sum : acc + sum; ACC_WIDTH wraps (two's complement).
  - On a valid beat with last: the stage register gets acc_next + bias (sign-extended, ACC_WIDTH) and S3 valid is set. The acc register is cleared to 0 in the same cycle, so a missing in_first on the next pixel is harmless.
  - A non-last beat produces no downstream valid.
- S4: registers p = S3 * scale at full ACC_WIDTH+SCALE_WIDTH width.
- S5 / output:
  - r = (p + (1 << (SHIFT-1))) >>> SHIFT, i.e. round half toward +inf.
  - r is then saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and passed through the ReLU option.
  - out_data and out_valid are registered.
- Latency: a last beat accepted at edge N gives out_valid high after edge N+5, with no stall.
- Throughput: 1 beat/cycle.
- out_data is stable while out_valid && !out_ready.
- first && last on the same beat means a single-channel pixel.
- Idle cycles (in_valid low) insert bubbles without disturbing acc.
- Reset asserted mid-operation discards partial sums and in-flight results. No output appears after release until a new last beat is accepted.

Optional Feature:
- Macro: CONV_KXK_RELU_EN.
- Defined: negative saturated results are forced to 0, so out_data is in [0, 2^(OUT_WIDTH-1)-1].
- Undefined: signed saturated result is output unchanged, full signed range.

Test Plan:
- Single-channel pixel, defaults: data all 1, weights all 2, bias 0, scale 65536, first = last = 1 → out_data 18, out_valid high exactly 5 cycles after acceptance.
- Three channels (first, mid, last), each with the same vectors as above, bias 6, scale 65536 → out_data 60; no out_valid on the first two beats.
- Saturation: data all 127, weights all 127, scale 65536 → 127. With data all -128, weights all 127:
  - RELU_EN off → -128;
  - RELU_EN on → 0.
- Rounding: tree sum 3, bias 0, scale 32768 → 2 (1.5 rounds up). Tree sum -3 → -1 (-1.5 rounds up) with RELU_EN off.
- Backpressure: continuous single-channel beats of value 18, 19, 20, 21 with out_ready low for 4 cycles mid-stream:
  - in_ready is low during the stall;
  - out_data holds;
  - sequence 18, 19, 20, 21 is delivered with no loss or duplication.
- Reset mid-pixel: accept first + mid beats, pulse rst_n low, then send a single first+last pixel of value 5 → only 5 is output, with no stale accumulation.
